// File: rtl/ram_sync_clr.sv
// Synchronous single-port RAM with valid/ready access, a one-cycle ack and a hardware zero-fill sequencer.
// Defining RAM_PARITY_EN adds a stored parity bit per word and a parity_err flag on reads.
module ram_sync_clr #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              perr_inject,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              clearing,
  output logic              parity_err
);

`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {CLEAR, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [MEM_W-1:0]  mem_q [DEPTH];

  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  mem_rword;
  logic [MEM_W-1:0]  write_word;

  // clr blocks acceptance combinationally so the restart edge never mixes with a user access
  assign ready     = (state_q == RUN) && !clr;
  assign accept    = req && ready;
  assign clearing  = (state_q == CLEAR);
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign mem_rword = mem_q[addr];

`ifdef RAM_PARITY_EN
  assign write_word = {(^wdata) ^ perr_inject, wdata};
`else
  assign write_word = wdata;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = accept;
    rdata_d = rdata_q;
    case (state_q)
      CLEAR: begin
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_ADDR) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      RUN: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
    if (accept && !we) begin
      rdata_d = mem_rword[DATA_W-1:0];
    end
  end

  // The fill sequencer owns the write port while clearing; zero data also means zero parity
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = '0;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
    end else if (accept && we) begin
      mem_we    = 1'b1;
      mem_wdata = write_word;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef RAM_PARITY_EN
  logic parity_err_q, parity_err_d;

  // XOR over the whole stored word equals stored parity bit XOR recomputed data parity
  assign parity_err_d = accept && !we && (^mem_rword);
  assign parity_err   = parity_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end
`else
  logic unused_perr_inject;

  assign unused_perr_inject = perr_inject;
  assign parity_err         = 1'b0;
`endif

endmodule

// File: tb/tb_ram_sync_clr.sv
// Directed, table-driven bench for ram_sync_clr: fill timing, read/write vectors, bursts,
// clr restarts, mid-operation reset and the parity flag.
module tb_ram_sync_clr;

  logic        clk;
  logic        reset_n;
  logic        clr;
  logic        req;
  logic        we;
  logic [7:0]  addr;
  logic [11:0] wdata;
  logic        perr_inject;
  logic        ready;
  logic        ack;
  logic [11:0] rdata;
  logic        clearing;
  logic        parity_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [11:0] wdata;
    logic        perr;
    logic        exp_ack;
    logic [11:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

`ifdef RAM_PARITY_EN
  localparam logic EXP_INJECTED_PERR = 1'b1;
`else
  localparam logic EXP_INJECTED_PERR = 1'b0;
`endif

  ram_sync_clr #(.DATA_W(12), .ADDR_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr         (clr),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .perr_inject (perr_inject),
    .ready       (ready),
    .ack         (ack),
    .rdata       (rdata),
    .clearing    (clearing),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input logic r, input logic w, input logic [7:0] a,
                                 input logic [11:0] d, input logic p,
                                 input logic ea, input logic [11:0] er);
    vec_t v;
    v.req = r; v.we = w; v.addr = a; v.wdata = d; v.perr = p;
    v.exp_ack = ea; v.exp_rdata = er;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req         = v.req;
    we          = v.we;
    addr        = v.addr;
    wdata       = v.wdata;
    perr_inject = v.perr;
    tick();
  endtask

  task automatic idleInputs();
    req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 12'o0000; perr_inject = 1'b0;
  endtask

  // Counts edges until ready rises, also counting cycles where neither ready nor clearing is set
  task automatic waitReady(output int n);
    int odd = 0;
    n = 0;
    while (!ready && n < 600) begin
      tick();
      n++;
      if (!ready && !clearing) odd++;
    end
    checkOutput("clearing_during_fill", odd, 0);
    checkOutput("clearing_after_fill", clearing, 0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    clr     = 1'b0;
    idleInputs();

    // reset state
    repeat (3) tick();
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_clearing", clearing, 1);
    checkOutput("rst_parity_err", parity_err, 0);

    reset_n = 1'b1;
    waitReady(n);
    checkOutput("fill_edges_after_reset", n, 256);

    vecs.push_back(mkVec(1, 0, 8'd0,   12'o0000, 0, 1, 12'o0000));
    vecs.push_back(mkVec(1, 0, 8'd128, 12'o0000, 0, 1, 12'o0000));
    vecs.push_back(mkVec(1, 0, 8'd255, 12'o0000, 0, 1, 12'o0000));
    vecs.push_back(mkVec(0, 0, 8'd0,   12'o0000, 0, 0, 12'o0000));
    vecs.push_back(mkVec(1, 1, 8'h05,  12'o7777, 0, 1, 12'o0000));
    vecs.push_back(mkVec(1, 0, 8'h05,  12'o0000, 0, 1, 12'o7777));
    vecs.push_back(mkVec(1, 1, 8'h06,  12'o0042, 0, 1, 12'o7777));
    vecs.push_back(mkVec(0, 0, 8'h06,  12'o0000, 0, 0, 12'o7777));
    vecs.push_back(mkVec(1, 1, 8'h07,  12'o0123, 0, 1, 12'o7777));
    vecs.push_back(mkVec(1, 0, 8'h07,  12'o0000, 0, 1, 12'o0123));
    vecs.push_back(mkVec(1, 0, 8'h06,  12'o0000, 0, 1, 12'o0042));
    vecs.push_back(mkVec(1, 0, 8'h05,  12'o0000, 0, 1, 12'o7777));
    vecs.push_back(mkVec(0, 1, 8'h05,  12'o1111, 0, 0, 12'o7777));
    vecs.push_back(mkVec(1, 0, 8'h05,  12'o0000, 0, 1, 12'o7777));
    vecs.push_back(mkVec(1, 1, 8'hFF,  12'o5555, 0, 1, 12'o7777));
    vecs.push_back(mkVec(0, 0, 8'h00,  12'o0000, 0, 0, 12'o7777));
    vecs.push_back(mkVec(1, 0, 8'hFF,  12'o0000, 0, 1, 12'o5555));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_ack", i), ack, vecs[i].exp_ack);
      checkOutput($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_perr", i), parity_err, 0);
    end
    idleInputs();
    tick();

    // back-to-back writes then reads, continuous ack
    for (int i = 0; i < 256; i++) begin
      applyStimulus(mkVec(1, 1, 8'(i), 12'(i), 0, 1, 12'o0000));
      checkOutput($sformatf("bw%0d_ack", i), ack, 1);
    end
    for (int i = 0; i < 256; i++) begin
      applyStimulus(mkVec(1, 0, 8'(i), 12'o0000, 0, 1, 12'o0000));
      checkOutput($sformatf("br%0d_ack", i), ack, 1);
      checkOutput($sformatf("br%0d_rdata", i), rdata, i);
    end
    idleInputs();
    tick();
    checkOutput("burst_end_ack", ack, 0);
    checkOutput("burst_end_rdata_hold", rdata, 255);

    // clr in RUN together with a request
    applyStimulus(mkVec(1, 1, 8'h10, 12'o1234, 0, 1, 12'o0000));
    clr = 1'b1; req = 1'b1; we = 1'b0; addr = 8'h10;
    #1;
    checkOutput("clr_ready_comb", ready, 0);
    checkOutput("clr_prev_ack", ack, 1);
    tick();
    checkOutput("clr_req_no_ack", ack, 0);
    checkOutput("clr_clearing", clearing, 1);
    clr = 1'b0;
    idleInputs();
    waitReady(n);
    checkOutput("clr_edges_to_ready", n + 1, 257);
    applyStimulus(mkVec(1, 0, 8'h10, 12'o0000, 0, 1, 12'o0000));
    checkOutput("clr_read_ack", ack, 1);
    checkOutput("clr_read_zero", rdata, 0);
    idleInputs();

    // clr while already clearing restarts the count
    applyStimulus(mkVec(1, 1, 8'h11, 12'o0777, 0, 1, 12'o0000));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (49) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    waitReady(n);
    checkOutput("clr_in_clear_edges", n + 1, 257);

    // reset in the middle of a read burst
    applyStimulus(mkVec(1, 1, 8'h20, 12'o4321, 0, 1, 12'o0000));
    applyStimulus(mkVec(1, 0, 8'h20, 12'o0000, 0, 1, 12'o4321));
    checkOutput("pre_rst_rdata", rdata, 12'o4321);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_ack", ack, 0);
    checkOutput("midrst_rdata", rdata, 0);
    checkOutput("midrst_clearing", clearing, 1);
    checkOutput("midrst_ready", ready, 0);
    idleInputs();
    tick();
    tick();
    reset_n = 1'b1;
    waitReady(n);
    checkOutput("midrst_fill_edges", n, 256);
    applyStimulus(mkVec(1, 0, 8'h20, 12'o0000, 0, 1, 12'o0000));
    checkOutput("midrst_read_ack", ack, 1);
    checkOutput("midrst_read_zero", rdata, 0);

    // parity: injected error, then a clean word
    applyStimulus(mkVec(1, 1, 8'h30, 12'o0001, 1, 1, 12'o0000));
    applyStimulus(mkVec(1, 0, 8'h30, 12'o0000, 0, 1, 12'o0001));
    checkOutput("par_inj_ack", ack, 1);
    checkOutput("par_inj_rdata", rdata, 12'o0001);
    checkOutput("par_inj_err", parity_err, EXP_INJECTED_PERR);
    idleInputs();
    tick();
    checkOutput("par_idle_err", parity_err, 0);
    applyStimulus(mkVec(1, 1, 8'h31, 12'o0003, 0, 1, 12'o0001));
    applyStimulus(mkVec(1, 0, 8'h31, 12'o0000, 0, 1, 12'o0003));
    checkOutput("par_ok_rdata", rdata, 12'o0003);
    checkOutput("par_ok_err", parity_err, 0);
    idleInputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
